// File: rtl/dlx_single_cycle_core.sv
// dlx_single_cycle_core: single-cycle 32-bit DLX-style integer core.
// Every rising clock edge retires one instruction. Instruction fetch is an
// asynchronous read of inst_from_mem at iaddr. The data memory reads
// combinationally and writes on the clock edge.
//
// The specification numbers bits big-endian, so its bit 0 is the MSB. Fields
// here use ordinary [31:0] vectors with this mapping:
//   opcode [0:5]  -> inst[31:26]    rs1 [6:10]     -> inst[25:21]
//   I rd   [11:15]-> inst[20:16]    imm16 [16:31]  -> inst[15:0]
//   R rs2  [11:15]-> inst[20:16]    R rd [16:20]   -> inst[15:11]
//   func   [26:31]-> inst[5:0]      off26 [6:31]   -> inst[25:0]
//
// Optional build macro DLX_TRAP_HALT_EN: when it is defined, opcode 0x11
// (trap) freezes the PC and blocks all register and memory writes until
// reset. When it is undefined, trap executes as a nop.

module dlx_single_cycle_core #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          REGFILE_DEPTH = 32
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] iaddr,
    input  logic [31:0] inst_from_mem,
    output logic [31:0] addr_to_mem,
    output logic        write_enable_to_mem,
    output logic        byte_to_mem,
    output logic        half_word_to_mem,
    output logic        sign_extend_to_mem,
    output logic [31:0] data_to_mem,
    input  logic [31:0] data_from_mem
);

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDUI = 6'h09;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_SUBUI = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LHI   = 6'h0F;
    localparam logic [5:0] OP_JR    = 6'h12;
    localparam logic [5:0] OP_JALR  = 6'h13;
    localparam logic [5:0] OP_SLLI  = 6'h14;
    localparam logic [5:0] OP_SRLI  = 6'h16;
    localparam logic [5:0] OP_SRAI  = 6'h17;
    localparam logic [5:0] OP_SEQI  = 6'h18;
    localparam logic [5:0] OP_SNEI  = 6'h19;
    localparam logic [5:0] OP_SLTI  = 6'h1A;
    localparam logic [5:0] OP_SGTI  = 6'h1B;
    localparam logic [5:0] OP_SLEI  = 6'h1C;
    localparam logic [5:0] OP_SGEI  = 6'h1D;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef DLX_TRAP_HALT_EN
    localparam logic [5:0] OP_TRAP  = 6'h11;
`endif

    // R-type function codes
    localparam logic [5:0] F_SLL  = 6'h04;
    localparam logic [5:0] F_SRL  = 6'h06;
    localparam logic [5:0] F_SRA  = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_SEQ  = 6'h28;
    localparam logic [5:0] F_SNE  = 6'h29;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SGT  = 6'h2B;
    localparam logic [5:0] F_SLE  = 6'h2C;
    localparam logic [5:0] F_SGE  = 6'h2D;

    localparam logic [4:0] LINK_REG = 5'd31;

    logic [31:0] pc;
    logic [31:0] regs [REGFILE_DEPTH];

    logic [5:0]  opcode;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_r_idx;
    logic [5:0]  func;
    logic [15:0] imm16;
    logic [25:0] off26;

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] off_sext;
    logic [31:0] pc_plus4;

    logic [31:0] next_pc;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        is_store;
    logic        acc_byte;
    logic        acc_half;
    logic        acc_sext;

`ifdef DLX_TRAP_HALT_EN
    logic        halted;
`endif

    assign opcode   = inst_from_mem[31:26];
    assign rs1_idx  = inst_from_mem[25:21];
    assign rs2_idx  = inst_from_mem[20:16];
    assign rd_r_idx = inst_from_mem[15:11];
    assign func     = inst_from_mem[5:0];
    assign imm16    = inst_from_mem[15:0];
    assign off26    = inst_from_mem[25:0];

    // r0 is hardwired to zero on the read side; writes to it are dropped below
    assign rs1_val  = (rs1_idx == 5'd0) ? 32'h0 : regs[rs1_idx];
    assign rs2_val  = (rs2_idx == 5'd0) ? 32'h0 : regs[rs2_idx];

    assign imm_sext = {{16{imm16[15]}}, imm16};
    assign imm_zext = {16'h0, imm16};
    assign off_sext = {{6{off26[25]}}, off26};
    assign pc_plus4 = pc + 32'd4;

    // Signed set-on-compare; sel is the low 3 bits of func/opcode (seq..sge = 0..5)
    function automatic logic [31:0] cmp_set(input logic [2:0] sel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic r;
        r = 1'b0;
        case (sel)
            3'd0:    r = (a == b);
            3'd1:    r = (a != b);
            3'd2:    r = ($signed(a) <  $signed(b));
            3'd3:    r = ($signed(a) >  $signed(b));
            3'd4:    r = ($signed(a) <= $signed(b));
            3'd5:    r = ($signed(a) >= $signed(b));
            default: r = 1'b0;
        endcase
        return {31'h0, r};
    endfunction

    // Decode and execute: next PC, register write-back and memory strobes
    always_comb begin
        next_pc  = pc_plus4;
        rf_we    = 1'b0;
        rf_wa    = rs2_idx;
        rf_wd    = 32'h0;
        is_store = 1'b0;
        acc_byte = 1'b0;
        acc_half = 1'b0;
        acc_sext = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                rf_wa = rd_r_idx;
                rf_we = 1'b1;
                case (func)
                    F_ADD, F_ADDU: rf_wd = rs1_val + rs2_val;
                    F_SUB, F_SUBU: rf_wd = rs1_val - rs2_val;
                    F_AND:         rf_wd = rs1_val & rs2_val;
                    F_OR:          rf_wd = rs1_val | rs2_val;
                    F_XOR:         rf_wd = rs1_val ^ rs2_val;
                    F_SLL:         rf_wd = rs1_val << rs2_val[4:0];
                    F_SRL:         rf_wd = rs1_val >> rs2_val[4:0];
                    F_SRA:         rf_wd = $unsigned($signed(rs1_val) >>> rs2_val[4:0]);
                    F_SEQ, F_SNE, F_SLT, F_SGT, F_SLE, F_SGE:
                                   rf_wd = cmp_set(func[2:0], rs1_val, rs2_val);
                    default:       rf_we = 1'b0;
                endcase
            end

            // Unsigned-immediate forms take a zero-extended immediate
            OP_ADDI:  begin rf_we = 1'b1; rf_wd = rs1_val + imm_sext; end
            OP_ADDUI: begin rf_we = 1'b1; rf_wd = rs1_val + imm_zext; end
            OP_SUBI:  begin rf_we = 1'b1; rf_wd = rs1_val - imm_sext; end
            OP_SUBUI: begin rf_we = 1'b1; rf_wd = rs1_val - imm_zext; end
            OP_ANDI:  begin rf_we = 1'b1; rf_wd = rs1_val & imm_zext; end
            OP_ORI:   begin rf_we = 1'b1; rf_wd = rs1_val | imm_zext; end
            OP_XORI:  begin rf_we = 1'b1; rf_wd = rs1_val ^ imm_zext; end
            OP_LHI:   begin rf_we = 1'b1; rf_wd = {imm16, 16'h0}; end
            OP_SLLI:  begin rf_we = 1'b1; rf_wd = rs1_val << imm16[4:0]; end
            OP_SRLI:  begin rf_we = 1'b1; rf_wd = rs1_val >> imm16[4:0]; end
            OP_SRAI:  begin
                rf_we = 1'b1;
                rf_wd = $unsigned($signed(rs1_val) >>> imm16[4:0]);
            end
            OP_SEQI, OP_SNEI, OP_SLTI, OP_SGTI, OP_SLEI, OP_SGEI: begin
                rf_we = 1'b1;
                rf_wd = cmp_set(opcode[2:0], rs1_val, imm_sext);
            end

            OP_BEQZ: if (rs1_val == 32'h0) next_pc = pc_plus4 + imm_sext;
            OP_BNEZ: if (rs1_val != 32'h0) next_pc = pc_plus4 + imm_sext;

            OP_J:    next_pc = pc_plus4 + off_sext;
            OP_JAL:  begin
                next_pc = pc_plus4 + off_sext;
                rf_we   = 1'b1;
                rf_wa   = LINK_REG;
                rf_wd   = pc_plus4;
            end
            OP_JR:   next_pc = rs1_val;
            // rs1_val is read before the link write lands, so jalr r31 uses the old r31
            OP_JALR: begin
                next_pc = rs1_val;
                rf_we   = 1'b1;
                rf_wa   = LINK_REG;
                rf_wd   = pc_plus4;
            end

            OP_LB:  begin rf_we = 1'b1; rf_wd = data_from_mem; acc_byte = 1'b1; acc_sext = 1'b1; end
            OP_LH:  begin rf_we = 1'b1; rf_wd = data_from_mem; acc_half = 1'b1; acc_sext = 1'b1; end
            OP_LW:  begin rf_we = 1'b1; rf_wd = data_from_mem; end
            OP_LBU: begin rf_we = 1'b1; rf_wd = data_from_mem; acc_byte = 1'b1; end
            OP_LHU: begin rf_we = 1'b1; rf_wd = data_from_mem; acc_half = 1'b1; end

            OP_SB:  begin is_store = 1'b1; acc_byte = 1'b1; end
            OP_SH:  begin is_store = 1'b1; acc_half = 1'b1; end
            OP_SW:  is_store = 1'b1;

            default: ;
        endcase

`ifdef DLX_TRAP_HALT_EN
        // A trap, or the sticky halt it leaves behind, holds PC and blocks every write
        if (halted || (opcode == OP_TRAP)) begin
            next_pc  = pc;
            rf_we    = 1'b0;
            is_store = 1'b0;
            acc_byte = 1'b0;
            acc_half = 1'b0;
            acc_sext = 1'b0;
        end
`endif
    end

    assign iaddr               = pc;
    assign addr_to_mem         = rs1_val + imm_sext;
    assign data_to_mem         = rs2_val;
    assign write_enable_to_mem = is_store & ~reset;
    assign byte_to_mem         = acc_byte;
    assign half_word_to_mem    = acc_half;
    assign sign_extend_to_mem  = acc_sext;

    // Architectural state: PC and register file, cleared by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
            for (int i = 0; i < REGFILE_DEPTH; i++) begin
                regs[i] <= 32'h0;
            end
        end else begin
            pc <= next_pc;
            if (rf_we && (rf_wa != 5'd0)) begin
                regs[rf_wa] <= rf_wd;
            end
        end
    end

`ifdef DLX_TRAP_HALT_EN
    // Sticky halt flag, set by an executed trap and cleared only by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            halted <= 1'b0;
        end else if (opcode == OP_TRAP) begin
            halted <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dlx_single_cycle_core.sv
// Directed bench for dlx_single_cycle_core: a single program image runs
// through reset, arithmetic, loads and stores, branches, jumps, r0 handling
// and a Fibonacci loop. The bench models the instruction memory and a
// big-endian byte data memory.

module tb_dlx_single_cycle_core;

    logic        clock;
    logic        reset;
    logic [31:0] iaddr;
    logic [31:0] inst_from_mem;
    logic [31:0] addr_to_mem;
    logic        write_enable_to_mem;
    logic        byte_to_mem;
    logic        half_word_to_mem;
    logic        sign_extend_to_mem;
    logic [31:0] data_to_mem;
    logic [31:0] data_from_mem;

    logic [31:0] imem [1024];
    logic [7:0]  dmem [16384];

    int n_cmp;
    int n_bad;

    dlx_single_cycle_core dut (
        .clock               (clock),
        .reset               (reset),
        .iaddr               (iaddr),
        .inst_from_mem       (inst_from_mem),
        .addr_to_mem         (addr_to_mem),
        .write_enable_to_mem (write_enable_to_mem),
        .byte_to_mem         (byte_to_mem),
        .half_word_to_mem    (half_word_to_mem),
        .sign_extend_to_mem  (sign_extend_to_mem),
        .data_to_mem         (data_to_mem),
        .data_from_mem       (data_from_mem)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign inst_from_mem = imem[iaddr[11:2]];

    // Data memory read: aligned and extended as the core expects
    always_comb begin
        logic [13:0] ma;
        ma = addr_to_mem[13:0];
        if (byte_to_mem === 1'b1)
            data_from_mem = (sign_extend_to_mem === 1'b1) ? {{24{dmem[ma][7]}}, dmem[ma]}
                                                          : {24'h0, dmem[ma]};
        else if (half_word_to_mem === 1'b1)
            data_from_mem = (sign_extend_to_mem === 1'b1)
                          ? {{16{dmem[ma][7]}}, dmem[ma], dmem[ma + 14'd1]}
                          : {16'h0, dmem[ma], dmem[ma + 14'd1]};
        else
            data_from_mem = {dmem[ma], dmem[ma + 14'd1], dmem[ma + 14'd2], dmem[ma + 14'd3]};
    end

    // Data memory write on the clock edge
    always @(posedge clock) begin
        if (write_enable_to_mem === 1'b1) begin
            if (byte_to_mem === 1'b1) begin
                dmem[addr_to_mem[13:0]] <= data_to_mem[7:0];
            end else if (half_word_to_mem === 1'b1) begin
                dmem[addr_to_mem[13:0]]         <= data_to_mem[15:8];
                dmem[addr_to_mem[13:0] + 14'd1] <= data_to_mem[7:0];
            end else begin
                dmem[addr_to_mem[13:0]]         <= data_to_mem[31:24];
                dmem[addr_to_mem[13:0] + 14'd1] <= data_to_mem[23:16];
                dmem[addr_to_mem[13:0] + 14'd2] <= data_to_mem[15:8];
                dmem[addr_to_mem[13:0] + 14'd3] <= data_to_mem[7:0];
            end
        end
    end

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rd, input logic [15:0] imm);
        return {op, rs, rd, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs1, rs2, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] off);
        return {op, off};
    endfunction

    function automatic logic [31:0] dword(input int a);
        return {dmem[a], dmem[a + 1], dmem[a + 2], dmem[a + 3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        imem[addr >> 2] = w;
    endtask

    // Advance to the next mid-cycle point and check the fetch address
    task automatic step(input logic [31:0] exp_pc);
        @(negedge clock);
        chk($sformatf("pc@%h", exp_pc), iaddr, exp_pc);
    endtask

    task automatic chk_store(input string tag, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_we"},   {31'h0, write_enable_to_mem}, 32'h1);
        chk({tag, "_addr"}, addr_to_mem, a);
        chk({tag, "_data"}, data_to_mem, d);
    endtask

    logic [31:0] fib [6];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        fib[0] = 32'd1; fib[1] = 32'd1; fib[2] = 32'd2;
        fib[3] = 32'd3; fib[4] = 32'd5; fib[5] = 32'd8;

        for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
        for (int i = 0; i < 16384; i++) dmem[i] = 8'h00;
        dmem[16'h10] = 8'h80;

        put(32'h00, itype(6'h2B, 5'd0, 5'd1, 16'h2004));     // sw 0x2004(r0),r1
        put(32'h04, itype(6'h08, 5'd0, 5'd1, 16'd5));        // addi r1,r0,5
        put(32'h08, itype(6'h08, 5'd0, 5'd2, 16'd7));        // addi r2,r0,7
        put(32'h0C, rtype(5'd1, 5'd2, 5'd3, 6'h20));         // add r3,r1,r2
        put(32'h10, itype(6'h2B, 5'd0, 5'd3, 16'h2000));     // sw 0x2000(r0),r3
        put(32'h14, itype(6'h20, 5'd0, 5'd4, 16'h0010));     // lb r4,0x10(r0)
        put(32'h18, itype(6'h2B, 5'd0, 5'd4, 16'h2008));     // sw 0x2008(r0),r4
        put(32'h1C, itype(6'h24, 5'd0, 5'd4, 16'h0010));     // lbu r4,0x10(r0)
        put(32'h20, itype(6'h04, 5'd0, 5'd0, 16'd8));        // beqz r0,+8
        put(32'h24, itype(6'h08, 5'd0, 5'd4, 16'd1));        // skipped
        put(32'h28, itype(6'h08, 5'd0, 5'd4, 16'd1));        // skipped
        put(32'h2C, itype(6'h2B, 5'd0, 5'd4, 16'h200C));     // sw 0x200C(r0),r4
        put(32'h30, itype(6'h05, 5'd0, 5'd0, 16'd8));        // bnez r0,+8 (not taken)
        put(32'h34, itype(6'h05, 5'd1, 5'd0, 16'd4));        // bnez r1,+4 (taken)
        put(32'h38, itype(6'h08, 5'd0, 5'd1, 16'd99));       // skipped
        put(32'h3C, itype(6'h04, 5'd1, 5'd0, 16'h0100));     // beqz r1 (not taken)
        put(32'h40, jtype(6'h03, 26'h100));                  // jal +0x100
        put(32'h144, itype(6'h2B, 5'd0, 5'd31, 16'h2010));   // sw 0x2010(r0),r31
        put(32'h148, itype(6'h12, 5'd31, 5'd0, 16'h0));      // jr r31
        put(32'h44, itype(6'h08, 5'd0, 5'd0, 16'd9));        // addi r0,r0,9
        put(32'h48, rtype(5'd0, 5'd0, 5'd5, 6'h20));         // add r5,r0,r0
        put(32'h4C, itype(6'h2B, 5'd0, 5'd5, 16'h2014));     // sw 0x2014(r0),r5
        put(32'h50, rtype(5'd1, 5'd2, 5'd6, 6'h22));         // sub r6,r1,r2
        put(32'h54, rtype(5'd6, 5'd1, 5'd7, 6'h2A));         // slt r7,r6,r1
        put(32'h58, rtype(5'd6, 5'd1, 5'd8, 6'h06));         // srl r8,r6,r1
        put(32'h5C, itype(6'h0F, 5'd0, 5'd9, 16'h8001));     // lhi r9,0x8001
        put(32'h60, itype(6'h0D, 5'd9, 5'd9, 16'hFFFF));     // ori r9,r9,0xFFFF
        put(32'h64, itype(6'h2B, 5'd0, 5'd6, 16'h2018));
        put(32'h68, itype(6'h2B, 5'd0, 5'd7, 16'h201C));
        put(32'h6C, itype(6'h2B, 5'd0, 5'd8, 16'h2020));
        put(32'h70, itype(6'h2B, 5'd0, 5'd9, 16'h2024));
        put(32'h74, itype(6'h29, 5'd0, 5'd1, 16'h2028));     // sh 0x2028(r0),r1
        put(32'h78, itype(6'h21, 5'd0, 5'd10, 16'h2028));    // lh r10,0x2028(r0)
        put(32'h7C, itype(6'h2B, 5'd0, 5'd10, 16'h202C));
        put(32'h80, itype(6'h08, 5'd0, 5'd1, 16'd1));        // fib setup
        put(32'h84, itype(6'h08, 5'd0, 5'd2, 16'd1));
        put(32'h88, itype(6'h08, 5'd0, 5'd3, 16'd0));
        put(32'h8C, itype(6'h08, 5'd0, 5'd11, 16'd3));
        put(32'h90, itype(6'h2B, 5'd3, 5'd1, 16'h3000));     // loop: sw 0x3000(r3),r1
        put(32'h94, itype(6'h2B, 5'd3, 5'd2, 16'h3004));     // sw 0x3004(r3),r2
        put(32'h98, rtype(5'd1, 5'd2, 5'd1, 6'h20));         // add r1,r1,r2
        put(32'h9C, rtype(5'd1, 5'd2, 5'd2, 6'h20));         // add r2,r1,r2
        put(32'hA0, itype(6'h08, 5'd3, 5'd3, 16'd8));        // addi r3,r3,8
        put(32'hA4, itype(6'h0A, 5'd11, 5'd11, 16'd1));      // subi r11,r11,1
        put(32'hA8, itype(6'h05, 5'd11, 5'd0, 16'hFFE4));    // bnez r11,loop
        put(32'hAC, itype(6'h08, 5'd0, 5'd31, 16'h00C0));    // addi r31,r0,0xC0
        put(32'hB0, itype(6'h13, 5'd31, 5'd0, 16'h0));       // jalr r31
        put(32'hC0, itype(6'h2B, 5'd0, 5'd31, 16'h2030));    // sw 0x2030(r0),r31
        put(32'hC4, jtype(6'h11, 26'h0));                    // trap

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_we", {31'h0, write_enable_to_mem}, 32'h0);
        chk("rst_pc", iaddr, 32'h0);
        reset = 1'b0;
        #1;
        chk_store("sw_r1_after_reset", 32'h2004, 32'h0);

        step(32'h04); step(32'h08); step(32'h0C);
        step(32'h10);
        chk_store("sw_sum", 32'h2000, 32'd12);
        chk("sw_byte", {31'h0, byte_to_mem}, 32'h0);
        chk("sw_half", {31'h0, half_word_to_mem}, 32'h0);
        chk("sw_sext", {31'h0, sign_extend_to_mem}, 32'h0);

        step(32'h14);
        chk("lb_addr", addr_to_mem, 32'h10);
        chk("lb_byte", {31'h0, byte_to_mem}, 32'h1);
        chk("lb_sext", {31'h0, sign_extend_to_mem}, 32'h1);
        chk("lb_we",   {31'h0, write_enable_to_mem}, 32'h0);
        step(32'h18);
        chk_store("sw_lb", 32'h2008, 32'hFFFF_FF80);
        step(32'h1C);
        chk("lbu_byte", {31'h0, byte_to_mem}, 32'h1);
        chk("lbu_sext", {31'h0, sign_extend_to_mem}, 32'h0);
        step(32'h20);
        step(32'h2C);
        chk_store("sw_lbu", 32'h200C, 32'h0000_0080);
        step(32'h30);
        step(32'h34);
        step(32'h3C);
        step(32'h40);
        step(32'h144);
        chk_store("sw_link", 32'h2010, 32'h44);
        step(32'h148);
        step(32'h44);
        step(32'h48);
        step(32'h4C);
        chk_store("sw_r0", 32'h2014, 32'h0);
        step(32'h50); step(32'h54); step(32'h58); step(32'h5C); step(32'h60);
        step(32'h64); chk_store("sw_sub", 32'h2018, 32'hFFFF_FFFE);
        step(32'h68); chk_store("sw_slt", 32'h201C, 32'h1);
        step(32'h6C); chk_store("sw_srl", 32'h2020, 32'h07FF_FFFF);
        step(32'h70); chk_store("sw_lhi_ori", 32'h2024, 32'h8001_FFFF);
        step(32'h74);
        chk_store("sh", 32'h2028, 32'h5);
        chk("sh_half", {31'h0, half_word_to_mem}, 32'h1);
        chk("sh_byte", {31'h0, byte_to_mem}, 32'h0);
        step(32'h78);
        chk("lh_half", {31'h0, half_word_to_mem}, 32'h1);
        chk("lh_sext", {31'h0, sign_extend_to_mem}, 32'h1);
        step(32'h7C); chk_store("sw_lh", 32'h202C, 32'h5);
        step(32'h80); step(32'h84); step(32'h88); step(32'h8C);

        for (int it = 0; it < 3; it++) begin
            step(32'h90);
            chk_store($sformatf("fib%0d", 2 * it), 32'h3000 + 32'(8 * it), fib[2 * it]);
            step(32'h94);
            chk_store($sformatf("fib%0d", 2 * it + 1), 32'h3004 + 32'(8 * it), fib[2 * it + 1]);
            step(32'h98); step(32'h9C); step(32'hA0); step(32'hA4); step(32'hA8);
        end
        step(32'hAC);
        step(32'hB0);
        step(32'hC0);
        chk_store("sw_jalr_link", 32'h2030, 32'hB4);
        step(32'hC4);
        chk("trap_we", {31'h0, write_enable_to_mem}, 32'h0);
`ifdef DLX_TRAP_HALT_EN
        step(32'hC4);
`else
        step(32'hC8);
`endif
        @(negedge clock);

        chk("mem_sum",  dword(32'h2000), 32'd12);
        chk("mem_half", {16'h0, dmem[32'h2028], dmem[32'h2029]}, 32'h5);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("mem_fib%0d", k), dword(32'h3000 + 4 * k), fib[k]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
